// File: rtl/fx2_fft_bridge_if.sv
// FX2 slave-FIFO pin bundle between the bridge (master) and the FX2 chip (slave).
interface fx2_fft_bridge_if #(
  parameter int DW = 16
);
  logic          fx2_flaga;
  logic          fx2_flagb;
  logic          fx2_slcs_n;
  logic          fx2_slrd_n;
  logic          fx2_slwr_n;
  logic          fx2_sloe_n;
  logic          fx2_pktend_n;
  logic [1:0]    fx2_a;
  logic [DW-1:0] fx2_db_i;
  logic [DW-1:0] fx2_db_o;
  logic          fx2_db_oe;

  modport master (
    input  fx2_flaga, fx2_flagb, fx2_db_i,
    output fx2_slcs_n, fx2_slrd_n, fx2_slwr_n,
    output fx2_sloe_n, fx2_pktend_n, fx2_a,
    output fx2_db_o, fx2_db_oe
  );

  modport slave (
    output fx2_flaga, fx2_flagb, fx2_db_i,
    input  fx2_slcs_n, fx2_slrd_n, fx2_slwr_n,
    input  fx2_sloe_n, fx2_pktend_n, fx2_a,
    input  fx2_db_o, fx2_db_oe
  );
endinterface

// File: rtl/fx2_fft_bridge.sv
// FX2 slave-FIFO <-> FFT core bridge: weight/frame loads in, result packets out.
// Define FX2_FRAME_TAG_EN to append a frame-counter trailer word to each IN packet.
module fx2_fft_bridge #(
  parameter int         NPOINT   = 3,
  parameter int         DW       = 16,
  parameter logic [1:0] RD_ADDR  = 2'b00,
  parameter logic [1:0] WR_ADDR  = 2'b10,
  parameter int         TURN_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  fx2_fft_bridge_if.master             fx2,
  output logic                         weight_valid,
  output logic [2*NPOINT-1:0]          weight_idx,
  output logic [DW-1:0]                weight_real,
  output logic [DW-1:0]                weight_imag,
  output logic                         din_valid,
  input  logic                         din_ready,
  output logic [DW*(2**NPOINT)-1:0]    din_real,
  output logic [DW*(2**NPOINT)-1:0]    din_imag,
  input  logic                         dout_valid,
  output logic                         dout_ready,
  input  logic [DW*(2**NPOINT)-1:0]    dout_real,
  input  logic [DW*(2**NPOINT)-1:0]    dout_imag,
  output logic                         hdr_err
);

  localparam int N  = 2**NPOINT;
  localparam int W  = NPOINT * (2**(NPOINT-1));
  localparam int CW = 2*NPOINT + 1;
  localparam int TW = $clog2(TURN_CYC) + 1;
`ifdef FX2_FRAME_TAG_EN
  localparam int LEN = 2*N + 1;
`else
  localparam int LEN = 2*N;
`endif
  localparam logic [CW-1:0] WGT_LAST  = CW'(2*W - 1);
  localparam logic [CW-1:0] DAT_LAST  = CW'(2*N - 1);
  localparam logic [CW-1:0] TX_LAST   = CW'(LEN - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, RD_SEL, RD_HDR, RD_WGT, RD_DAT,
    DIN_HOLD, WR_SEL, WR_DAT, WR_PKT
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [TW-1:0]       turn_q;
  logic                slcs_n_q, sloe_n_q, db_oe_q;
  logic [1:0]          a_q;
  logic                wv_q, dv_q, drdy_q, herr_q;
  logic [2*NPOINT-1:0] widx_q;
  logic [DW-1:0]       wre_q, wim_q;
  logic [DW*N-1:0]     dre_q, dim_q;
  logic [DW*N-1:0]     tre_q, tim_q;
`ifdef FX2_FRAME_TAG_EN
  logic [DW-1:0]       tag_q;
`endif

  logic                rd_fire, wr_fire, pk_fire;
  logic [NPOINT-1:0]   pt;
  logic [1:0]          opc;
  logic [DW-1:0]       tx_w;

  // Strobes follow the registered state but gate on the live FIFO flags.
  assign rd_fire = fx2.fx2_flaga &&
                   (state_q == RD_HDR ||
                    state_q == RD_WGT ||
                    state_q == RD_DAT);
  assign wr_fire = fx2.fx2_flagb && state_q == WR_DAT;
  assign pk_fire = fx2.fx2_flagb && state_q == WR_PKT;
  assign pt      = cnt_q[NPOINT:1];
  assign opc     = fx2.fx2_db_i[DW-1:DW-2];

  always_comb begin
    tx_w = cnt_q[0] ? tim_q[pt*DW +: DW]
                    : tre_q[pt*DW +: DW];
`ifdef FX2_FRAME_TAG_EN
    if (cnt_q == CW'(2*N)) tx_w = tag_q;
`endif
  end

  assign fx2.fx2_slrd_n   = !rd_fire;
  assign fx2.fx2_slwr_n   = !wr_fire;
  assign fx2.fx2_pktend_n = !pk_fire;
  assign fx2.fx2_slcs_n   = slcs_n_q;
  assign fx2.fx2_sloe_n   = sloe_n_q;
  assign fx2.fx2_a        = a_q;
  assign fx2.fx2_db_o     = tx_w;
  assign fx2.fx2_db_oe    = db_oe_q;

  assign weight_valid = wv_q;
  assign weight_idx   = widx_q;
  assign weight_real  = wre_q;
  assign weight_imag  = wim_q;
  assign din_valid    = dv_q;
  assign din_real     = dre_q;
  assign din_imag     = dim_q;
  assign dout_ready   = drdy_q;
  assign hdr_err      = herr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      turn_q   <= '0;
      slcs_n_q <= 1'b1;
      sloe_n_q <= 1'b1;
      db_oe_q  <= 1'b0;
      a_q      <= RD_ADDR;
      wv_q     <= 1'b0;
      dv_q     <= 1'b0;
      drdy_q   <= 1'b0;
      herr_q   <= 1'b0;
      widx_q   <= '0;
      wre_q    <= '0;
      wim_q    <= '0;
      dre_q    <= '0;
      dim_q    <= '0;
      tre_q    <= '0;
      tim_q    <= '0;
`ifdef FX2_FRAME_TAG_EN
      tag_q    <= '0;
`endif
    end else begin
      wv_q   <= 1'b0;
      drdy_q <= 1'b0;
      herr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dout_valid) begin
            state_q  <= WR_SEL;
            drdy_q   <= 1'b1;
            tre_q    <= dout_real;
            tim_q    <= dout_imag;
            a_q      <= WR_ADDR;
            slcs_n_q <= 1'b0;
            db_oe_q  <= 1'b1;
            cnt_q    <= '0;
            turn_q   <= '0;
          end else if (fx2.fx2_flaga) begin
            state_q  <= RD_SEL;
            a_q      <= RD_ADDR;
            slcs_n_q <= 1'b0;
            sloe_n_q <= 1'b0;
            cnt_q    <= '0;
            turn_q   <= '0;
          end
        end
        RD_SEL, WR_SEL: begin
          if (turn_q == TURN_LAST)
            state_q <= (state_q == RD_SEL) ? RD_HDR : WR_DAT;
          else
            turn_q <= turn_q + TW'(1);
        end
        RD_HDR: begin
          if (rd_fire) begin
            unique case (1'b1)
              opc == 2'b01: state_q <= RD_WGT;
              opc == 2'b10: state_q <= RD_DAT;
              default: begin
                herr_q   <= 1'b1;
                state_q  <= IDLE;
                slcs_n_q <= 1'b1;
                sloe_n_q <= 1'b1;
              end
            endcase
          end
        end
        RD_WGT: begin
          if (rd_fire) begin
            cnt_q <= cnt_q + CW'(1);
            if (!cnt_q[0]) begin
              wre_q <= fx2.fx2_db_i;
            end else begin
              wim_q  <= fx2.fx2_db_i;
              widx_q <= cnt_q[CW-1:1];
              wv_q   <= 1'b1;
            end
            if (cnt_q == WGT_LAST) begin
              state_q  <= IDLE;
              slcs_n_q <= 1'b1;
              sloe_n_q <= 1'b1;
            end
          end
        end
        RD_DAT: begin
          if (rd_fire) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q[0]) dim_q[pt*DW +: DW] <= fx2.fx2_db_i;
            else          dre_q[pt*DW +: DW] <= fx2.fx2_db_i;
            if (cnt_q == DAT_LAST) begin
              state_q  <= DIN_HOLD;
              dv_q     <= 1'b1;
              slcs_n_q <= 1'b1;
              sloe_n_q <= 1'b1;
            end
          end
        end
        DIN_HOLD: begin
          if (din_ready) begin
            dv_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        WR_DAT: begin
          if (wr_fire) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == TX_LAST) state_q <= WR_PKT;
          end
        end
        WR_PKT: begin
          if (pk_fire) begin
            state_q  <= IDLE;
            db_oe_q  <= 1'b0;
            slcs_n_q <= 1'b1;
`ifdef FX2_FRAME_TAG_EN
            tag_q    <= tag_q + DW'(1);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_fft_bridge.sv
// Directed bench for fx2_fft_bridge with a behavioural FX2 FIFO model.
module tb_fx2_fft_bridge;
  localparam int NP = 3;
  localparam int N  = 8;
  localparam int DW = 16;
`ifdef FX2_FRAME_TAG_EN
  localparam int LEN = 2*N + 1;
`else
  localparam int LEN = 2*N;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fx2_fft_bridge_if #(.DW(DW)) bus ();

  logic              weight_valid;
  logic [2*NP-1:0]   weight_idx;
  logic [DW-1:0]     weight_real, weight_imag;
  logic              din_valid, din_ready;
  logic [DW*N-1:0]   din_real, din_imag;
  logic              dout_valid, dout_ready;
  logic [DW*N-1:0]   dout_real, dout_imag;
  logic              hdr_err;

  fx2_fft_bridge #(
    .NPOINT(NP), .DW(DW), .RD_ADDR(2'b00),
    .WR_ADDR(2'b10), .TURN_CYC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fx2(bus),
    .weight_valid(weight_valid),
    .weight_idx(weight_idx),
    .weight_real(weight_real),
    .weight_imag(weight_imag),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_real(din_real), .din_imag(din_imag),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_real(dout_real), .dout_imag(dout_imag),
    .hdr_err(hdr_err)
  );

  // FX2 FIFO model: OUT words queued by the stimulus, IN words logged.
  logic [DW-1:0] out_mem [256];
  logic [DW-1:0] wr_log  [256];
  logic [DW-1:0] w_re [64], w_im [64];
  logic [2*NP-1:0] w_ix [64];
  int rd_ptr = 0, rd_len = 0, wr_n = 0, pk_n = 0;
  int wv_n = 0, he_n = 0, dr_n = 0;
  logic stall_a, flagb;
  int checks = 0, failures = 0;

  assign bus.fx2_flaga = !stall_a && (rd_ptr < rd_len);
  assign bus.fx2_flagb = flagb;
  assign bus.fx2_db_i  = out_mem[rd_ptr[7:0]];

  always @(posedge clk) begin
    if (!bus.fx2_slrd_n) rd_ptr <= rd_ptr + 1;
    if (!bus.fx2_slwr_n) begin
      wr_log[wr_n[7:0]] <= bus.fx2_db_o;
      wr_n <= wr_n + 1;
    end
    if (!bus.fx2_pktend_n) pk_n <= pk_n + 1;
    if (weight_valid) begin
      w_ix[wv_n[5:0]] <= weight_idx;
      w_re[wv_n[5:0]] <= weight_real;
      w_im[wv_n[5:0]] <= weight_imag;
      wv_n <= wv_n + 1;
    end
    if (hdr_err) he_n <= he_n + 1;
    if (dout_ready) dr_n <= dr_n + 1;
  end

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    out_mem[rd_len[7:0]] = w;
    rd_len++;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_strb"},
        {bus.fx2_slcs_n, bus.fx2_slrd_n, bus.fx2_slwr_n,
         bus.fx2_sloe_n, bus.fx2_pktend_n}, 5'b11111);
    chk({tag, "_a"}, bus.fx2_a, 2'b00);
    chk({tag, "_lo"},
        {bus.fx2_db_oe, weight_valid, din_valid,
         dout_ready, hdr_err}, 5'b00000);
    chk({tag, "_din"}, {din_real, din_imag}, '0);
  endtask

  task automatic run_pkt(input bit do_stall, input int tag_exp);
    int wb, pb, db, sl;
    wb = wr_n; pb = pk_n; db = dr_n;
    for (int k = 0; k < N; k++) begin
      dout_real[k*DW +: DW] = DW'(k);
      dout_imag[k*DW +: DW] = DW'(16'h100 + k);
    end
    dout_valid = 1'b1;
    for (int i = 0; i < 50 && !dout_ready; i++) @(negedge clk);
    chk("tmo_drdy", dout_ready, 1'b1);
    dout_valid = 1'b0;
    if (do_stall) begin
      for (int i = 0; i < 100 && wr_n < wb + 5; i++) @(negedge clk);
      flagb = 1'b0;
      sl = 0;
      repeat (3) begin
        #1 if (!bus.fx2_slwr_n || !bus.fx2_pktend_n) sl++;
        @(negedge clk);
      end
      chk("wr_stall_strb", sl, 0);
      chk("wr_stall_cnt", wr_n - wb, 5);
      flagb = 1'b1;
    end
    for (int i = 0; i < 100 && pk_n == pb; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("wr_len", wr_n - wb, LEN);
    for (int k = 0; k < N; k++) begin
      chk("wr_re", wr_log[(wb + 2*k) % 256], DW'(k));
      chk("wr_im", wr_log[(wb + 2*k + 1) % 256], DW'(16'h100 + k));
    end
`ifdef FX2_FRAME_TAG_EN
    chk("wr_tag", wr_log[(wb + 2*N) % 256], DW'(tag_exp));
`else
    if (tag_exp < 0) chk("tag_unused", tag_exp, 0);
`endif
    chk("pktend_n", pk_n - pb, 1);
    chk("drdy_pulse", dr_n - db, 1);
    chk("db_oe_off", {bus.fx2_db_oe, bus.fx2_slcs_n}, 2'b01);
  endtask

  logic [DW*N-1:0] ere, eim;
  int base, sc, dvc, he0, pk0;

  initial begin
    rst_n = 1'b0; stall_a = 1'b0; flagb = 1'b1;
    din_ready = 1'b0; dout_valid = 1'b0;
    dout_real = '0; dout_imag = '0;
    repeat (3) @(negedge clk);
    chk_idle_outs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Weight load: 12 pairs (1,2)..(23,24)
    push(16'h4000);
    for (int i = 1; i <= 24; i++) push(DW'(i));
    for (int i = 0; i < 400 && wv_n < 12; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("wgt_cnt", wv_n, 12);
    chk("wgt0", {w_ix[0], w_re[0], w_im[0]}, {6'd0, 16'd1, 16'd2});
    chk("wgt5", {w_ix[5], w_re[5], w_im[5]}, {6'd5, 16'd11, 16'd12});
    chk("wgt11", {w_ix[11], w_re[11], w_im[11]}, {6'd11, 16'd23, 16'd24});
    chk("wgt_idle", {bus.fx2_slcs_n, bus.fx2_sloe_n, din_valid}, 3'b110);

    // Data frame with a read stall, then an illegal header queued behind it
    base = rd_ptr;
    push(16'h8000);
    for (int i = 0; i < 2*N; i++) push(DW'(16'h10 + i));
    push(16'hC000);
    for (int i = 0; i < 100 && rd_ptr < base + 4; i++) @(negedge clk);
    stall_a = 1'b1;
    sc = 0;
    repeat (5) begin
      #1 if (!bus.fx2_slrd_n) sc++;
      @(negedge clk);
    end
    chk("rd_stall_strb", sc, 0);
    chk("rd_stall_cnt", rd_ptr - base, 4);
    stall_a = 1'b0;
    for (int i = 0; i < 100 && !din_valid; i++) @(negedge clk);
    chk("tmo_din", din_valid, 1'b1);
    dvc = 0; sc = 0;
    repeat (20) begin
      if (din_valid) dvc++;
      if (!bus.fx2_slrd_n) sc++;
      @(negedge clk);
    end
    chk("din_hold", dvc, 20);
    chk("din_noread", sc, 0);
    chk("din_ptr", rd_ptr - base, 17);
    for (int k = 0; k < N; k++) begin
      ere[k*DW +: DW] = DW'(16'h10 + 2*k);
      eim[k*DW +: DW] = DW'(16'h11 + 2*k);
    end
    chk("din_re0", din_real[15:0], 16'h10);
    chk("din_im7", din_imag[127:112], 16'h1F);
    chk("din_re", din_real, ere);
    chk("din_im", din_imag, eim);
    he0 = he_n;
    din_ready = 1'b1;
    @(negedge clk);
    din_ready = 1'b0;
    chk("din_clr", din_valid, 1'b0);
    for (int i = 0; i < 50 && he_n == he0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("hdr_err", he_n - he0, 1);
    chk("hdr_nowgt", wv_n, 12);
    chk("hdr_nodin", {din_valid, bus.fx2_slcs_n}, 2'b01);

    // Output packets
    run_pkt(1'b1, 0);
`ifdef FX2_FRAME_TAG_EN
    run_pkt(1'b0, 1);
`endif

    // Write beats read when both are pending in IDLE
    stall_a = 1'b1;
    base = rd_ptr;
    push(16'h8000);
    for (int i = 0; i < 2*N; i++) push(DW'(16'h30 + i));
    dout_valid = 1'b1;
    stall_a = 1'b0;
    @(negedge clk);
    chk("prio_sel", {bus.fx2_a, bus.fx2_db_oe, bus.fx2_sloe_n},
        {2'b10, 1'b1, 1'b1});
    chk("prio_drdy", dout_ready, 1'b1);
    dout_valid = 1'b0;
    pk0 = pk_n;
    for (int i = 0; i < 100 && pk_n == pk0; i++) @(negedge clk);
    chk("prio_pkt", pk_n - pk0, 1);

    // Async reset in the middle of the next read frame
    for (int i = 0; i < 100 && rd_ptr < base + 6; i++) @(negedge clk);
    chk("tmo_rdmid", rd_ptr >= base + 6, 1'b1);
    pk0 = pk_n;
    rst_n = 1'b0;
    #1 chk_idle_outs("arst");
    rd_len = rd_ptr;
    @(negedge clk);
    rst_n = 1'b1;
    base = rd_ptr;
    push(16'h8000);
    for (int i = 0; i < 2*N; i++) push(DW'(16'h20 + i));
    for (int i = 0; i < 100 && !din_valid; i++) @(negedge clk);
    chk("tmo_din2", din_valid, 1'b1);
    for (int k = 0; k < N; k++) begin
      ere[k*DW +: DW] = DW'(16'h20 + 2*k);
      eim[k*DW +: DW] = DW'(16'h21 + 2*k);
    end
    chk("rst_re", din_real, ere);
    chk("rst_im", din_imag, eim);
    chk("rst_nopkt", pk_n - pk0, 0);
    chk("rst_ptr", rd_ptr - base, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fx2_fft_bridge.md
Name: fx2_fft_bridge

Overview:
- Parametrised Cypress FX2 slave-FIFO bridge between the USB host and the FFT core; successor to the fixed 16-bit USB interface.
- Host packets carry a header word: opcode selects twiddle-weight load or data-frame load.
- FFT results are returned as one IN packet per frame, terminated by PKTEND.
- Adds flag-gated read/write strobes, a split data bus, a din/dout ready handshake and header error reporting.

Parameters:
- NPOINT, 3: log2 of FFT points; N = 2**NPOINT.
- DW, 16: sample and FX2 bus width.
- RD_ADDR, 2'b00: FIFOADR value for the OUT (host->FPGA) endpoint.
- WR_ADDR, 2'b10: FIFOADR value for the IN (FPGA->host) endpoint.
- TURN_CYC, 2: address/OE setup cycles before the first strobe after an endpoint switch (>=1).

Ports:
- clk  in  1  system clock, also FX2 IFCLK domain.
- rst_n  in  1  asynchronous active-low reset.
- fx2_flaga  in  1  OUT endpoint not empty.
- fx2_flagb  in  1  IN endpoint not full.
- fx2_slcs_n  out  1  chip select.
- fx2_slrd_n  out  1  read strobe.
- fx2_slwr_n  out  1  write strobe.
- fx2_sloe_n  out  1  FX2 output enable.
- fx2_pktend_n  out  1  packet end.
- fx2_a  out  2  FIFOADR.
- fx2_db_i  in  DW  bus input.
- fx2_db_o  out  DW  bus output.
- fx2_db_oe  out  1  pad drive enable.
- weight_valid  out  1  one-cycle weight strobe.
- weight_idx  out  2*NPOINT  weight index.
- weight_real, weight_imag  out  DW each  weight value.
- din_valid  out  1  input frame valid.
- din_ready  in  1  FFT accepts frame.
- din_real, din_imag  out  DW*N each  frame; point k at [k*DW +: DW].
- dout_valid  in  1  FFT result valid.
- dout_ready  out  1  result accepted.
- dout_real, dout_imag  in  DW*N each  result frame.
- hdr_err  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Reset values:
  - Strobes, slcs_n, sloe_n, pktend_n: 1.
  - fx2_a = RD_ADDR.
  - db_oe, weight_valid, din_valid, dout_ready, hdr_err: 0.
  - All data registers and counters: 0. FSM state: IDLE.
- Reset asserted mid-transfer drops partial frames; no PKTEND is issued.
- States: IDLE, RD_SEL, RD_HDR, RD_WGT, RD_DAT, DIN_HOLD, WR_SEL, WR_DAT, WR_PKT.
- IDLE:
  - dout_valid has priority: go to WR_SEL, pulse dout_ready for 1 cycle, capture dout_* into the TX buffer.
  - Else if flaga: go to RD_SEL.
- RD_SEL / WR_SEL:
  - Drive fx2_a = RD_ADDR / WR_ADDR and slcs_n = 0 for TURN_CYC cycles.
  - sloe_n = 0 during RD_SEL. db_oe = 1 during WR_SEL.
- Read strobe: fx2_slrd_n = !(state in {RD_HDR, RD_WGT, RD_DAT} && flaga), combinational from the registered state.
  - A word transfers on the rising edge while slrd_n = 0.
  - flaga = 0 stalls with no counter advance.
  - sloe_n stays 0 throughout the read states.
- Header opcode = db_i[DW-1:DW-2]:
  - 01: go to RD_WGT.
  - 10: go to RD_DAT.
  - Other: pulse hdr_err, return to IDLE; the word is consumed.
- RD_WGT:
  - Reads 2*W words, W = NPOINT*2**(NPOINT-1): even words are real, odd words are imag.
  - On each imag word: weight_valid = 1 next cycle with the pair and weight_idx = pair number (0..W-1).
  - After the last word: IDLE.
- RD_DAT:
  - Reads 2*N words: word 2k is real of point k, word 2k+1 is imag of point k.
  - After the last word: DIN_HOLD with din_valid = 1.
- DIN_HOLD:
  - din_* held stable; leave to IDLE on din_valid && din_ready, clearing din_valid that edge.
  - No FX2 reads occur in this state.
- WR_DAT:
  - fx2_slwr_n = !(state == WR_DAT && flagb); db_o = current TX word, same real/imag order as reads.
  - flagb = 0 stalls. After the last word: WR_PKT.
- WR_PKT:
  - pktend_n = 0 for exactly one cycle, only when flagb = 1; then IDLE, db_oe = 0.
- slcs_n = 0 in every state except IDLE and DIN_HOLD.
- Word counters are 2*NPOINT+1 bits wide and clear on every entry to a SEL state.
- dout_valid arriving during a read transfer waits until IDLE.

Optional Feature:
- Macro FX2_FRAME_TAG_EN.
- Defined:
  - Each IN packet carries one extra trailer word before PKTEND: a DW-bit frame counter.
  - The counter is 0 after reset, increments after each packet, and wraps at 2**DW-1 -> 0.
  - Packet length is 2*N+1 words.
- Undefined: packet length is 2*N words and no counter logic exists.

Test Plan:
- Weight load, NPOINT=3: header 0x4000 + 24 words 1..24 -> 12 weight_valid pulses; idx 0 = (1,2), idx 11 = (23,24); then IDLE.
- Data frame: header 0x8000 + words 0x10..0x1F, din_ready held low 20 cycles -> din_real point 0 = 0x10, din_imag point 7 = 0x1F, din_valid high for 20 cycles, no slrd_n low during the wait.
- Read stall: flaga low for 5 cycles after word 3 -> slrd_n high for those cycles, all 16 words still captured in order.
- Output packet: dout_valid with real[k] = k, imag[k] = 0x100+k, flagb low for 3 cycles mid-packet -> 16 writes 0,0x100,1,0x101,..., one pktend pulse; with FX2_FRAME_TAG_EN, 17th word = 0 then 1 on the next frame.
- Priority and error: dout_valid and flaga together in IDLE -> write first; header 0xC000 -> hdr_err pulse, no weight or din activity.
- Async reset mid-RD_DAT -> all outputs at reset values immediately, next header parsed fresh.
